// File: rtl/p_div.sv
// Iterative 96/48 unsigned restoring divider; ITER (=96/STEPS_PER_CYCLE) cycles per divide, 1 cycle for divide-by-zero.
// Accepts only while in_ready (IDLE); in_valid during CALC is dropped, results appear as a one-cycle out_valid pulse.
module p_div #(
  parameter int STEPS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] dividend,
  input  logic [47:0] divisor,
  output logic        out_valid,
  output logic [95:0] quotient,
  output logic [47:0] remainder,
  output logic        div_by_zero
);

  localparam int ITER = 96 / STEPS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [95:0]   q_sh;
  logic [48:0]   r_sh;
  logic [47:0]   dvs;
  logic [95:0]   q_nxt;
  logic [48:0]   r_nxt;

  assign in_ready = (state == IDLE);

  // Partial remainder is one bit wider than the divisor so the compare cannot overflow.
  always_comb begin
    q_nxt = q_sh;
    r_nxt = r_sh;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      r_nxt = {r_nxt[47:0], q_nxt[95]};
      q_nxt = {q_nxt[94:0], 1'b0};
      if (r_nxt >= {1'b0, dvs}) begin
        r_nxt    = r_nxt - {1'b0, dvs};
        q_nxt[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      q_sh        <= '0;
      r_sh        <= '0;
      dvs         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // Result outputs are zero except in the out_valid cycle.
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == 48'd0) begin
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[47:0];
              div_by_zero <= 1'b1;
            end else begin
              dvs   <= divisor;
              q_sh  <= dividend;
              r_sh  <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_sh <= q_nxt;
          r_sh <= r_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            out_valid <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt[47:0];
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_div.sv
// Directed bench for p_div: latency, results, divide-by-zero, back-to-back issue and mid-calculation reset.
module tb_p_div;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] dividend;
  logic [47:0] divisor;
  logic        out_valid;
  logic [95:0] quotient;
  logic [47:0] remainder;
  logic        div_by_zero;

  int vectors    = 0;
  int miscompares = 0;
  int n, lo, pulses;

  p_div dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands for one cycle; returns at the negedge just after the accept edge.
  task automatic issue(input logic [95:0] a, input logic [47:0] b);
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    in_valid = 1'b0; dividend = '1; divisor = 48'h5A5A;
  endtask

  // n = edges after the accept edge at which out_valid is seen; lo = cycles in_ready was low.
  task automatic wait_out(output int cyc, output int low);
    cyc = 0; low = 0;
    while (!out_valid && cyc < 200) begin
      if (!in_ready) low++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ov"}, {95'd0, out_valid}, 96'd0);
    chk({tag, "_q"},  quotient, 96'd0);
    chk({tag, "_r"},  {48'd0, remainder}, 96'd0);
    chk({tag, "_dz"}, {95'd0, div_by_zero}, 96'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk_idle_zero("rst");
    chk("rst_rdy", {95'd0, in_ready}, 96'd1);
    @(negedge clk); rst_n = 1'b1;

    // 1: 100/7, latency and in_ready low window
    issue(96'd100, 48'd7);
    wait_out(n, lo);
    chk("t1_lat", 96'(n), 96'd24);
    chk("t1_busy", 96'(lo), 96'd24);
    chk("t1_q", quotient, 96'd14);
    chk("t1_r", {48'd0, remainder}, 96'd2);
    chk("t1_dz", {95'd0, div_by_zero}, 96'd0);
    chk("t1_rdy", {95'd0, in_ready}, 96'd1);
    @(negedge clk);
    chk_idle_zero("t1_after");

    // 2: maximum multiplier product round trip
    issue(96'hFFFF_FFFF_FFFE_0000_0000_0001, 48'hFFFF_FFFF_FFFF);
    wait_out(n, lo);
    chk("t2_q", quotient, 96'h0000_0000_0000_FFFF_FFFF_FFFF);
    chk("t2_r", {48'd0, remainder}, 96'd0);

    // 3: dividend < divisor, then divisor 1 with full-width quotient
    issue(96'd5, 48'd9);
    wait_out(n, lo);
    chk("t3a_q", quotient, 96'd0);
    chk("t3a_r", {48'd0, remainder}, 96'd5);
    issue('1, 48'd1);
    wait_out(n, lo);
    chk("t3b_q", quotient, '1);
    chk("t3b_r", {48'd0, remainder}, 96'd0);

    // 4: divide by zero; result visible in the cycle right after the accept edge
    @(negedge clk);
    chk("t4_rdy_pre", {95'd0, in_ready}, 96'd1);
    issue(96'h1234_0000_0000_0000_ABCD, 48'd0);
    chk("t4_ov", {95'd0, out_valid}, 96'd1);
    chk("t4_q", quotient, '1);
    chk("t4_r", {48'd0, remainder}, 96'h0000_0000_ABCD);
    chk("t4_dz", {95'd0, div_by_zero}, 96'd1);
    chk("t4_rdy", {95'd0, in_ready}, 96'd1);
    @(negedge clk);
    chk_idle_zero("t4_after");

    // 5: stray in_valid during CALC, then back-to-back issue in the out_valid cycle
    issue(96'd100, 48'd7);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; dividend = 96'd999; divisor = 48'd0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(n, lo);
    chk("t5a_lat", 96'(n), 96'd18);
    chk("t5a_q", quotient, 96'd14);
    chk("t5a_r", {48'd0, remainder}, 96'd2);
    in_valid = 1'b1; dividend = 96'd200; divisor = 48'd3;
    @(negedge clk);
    in_valid = 1'b0; dividend = '0; divisor = 48'd1;
    chk("t5_busy", {95'd0, in_ready}, 96'd0);
    wait_out(n, lo);
    chk("t5b_lat", 96'(n), 96'd24);
    chk("t5b_q", quotient, 96'd66);
    chk("t5b_r", {48'd0, remainder}, 96'd2);

    // 6: reset mid-calculation abandons the result
    issue(96'd1000, 48'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("t6_rst");
    chk("t6_rdy", {95'd0, in_ready}, 96'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("t6_no_ov", 96'(pulses), 96'd0);
    chk("t6_rdy2", {95'd0, in_ready}, 96'd1);
    issue(96'd9, 48'd2);
    wait_out(n, lo);
    chk("t6_lat", 96'(n), 96'd24);
    chk("t6_q", quotient, 96'd4);
    chk("t6_r", {48'd0, remainder}, 96'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
